fetch_sequencer: RTL

Instruction-fetch controller for the rv32i single-cycle core. Owns the fetch PC, issues one-at-a-time requests to instruction memory over a valid/ready handshake, and buffers up to two returned instructions for decode. Consumes the branch unit's `jmp_enable`/`jmp_addr` to redirect fetch, flushing buffered and in-flight sequential fetches.

---
 rtl/fetch_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the fetch PC, keeps one imem request in flight and buffers two instructions.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirect targets enter a sticky trap instead of being truncated.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        jmp_enable,
  input  logic [31:0] jmp_addr,
  output logic        trap_misalign
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1
`ifdef FETCH_MISALIGN_TRAP_EN
    , TRAP = 2'd2
`endif
  } state_t;

  state_t      state;
  logic        active;
  logic        outstanding;
  logic        squash;
  logic [31:0] fetch_pc;
  logic [31:0] pend_pc;
  logic [1:0]  count;
  logic [31:0] data0, pc0, data1, pc1;

  logic [1:0]  count_n;
  logic [31:0] data0_n, pc0_n, data1_n, pc1_n;
  logic        accept, rsp, pop, redirect, push, bad_target;
  logic [1:0]  level;
  logic [31:0] target;

  // active holds requests off until the first cycle after reset is released
  assign imem_req_valid = active && (state == RUN) && !outstanding &&
                          (({1'b0, count} + {2'b00, outstanding}) < 3'd2);
  assign imem_req_addr  = fetch_pc;
  assign inst_valid     = (count != 2'd0);
  assign inst_data      = data0;
  assign inst_pc        = pc0;

  assign accept   = imem_req_valid && imem_req_ready;
  assign rsp      = imem_rsp_valid && outstanding;
  assign pop      = inst_valid && inst_ready;
  assign redirect = pop && jmp_enable;
  assign push     = rsp && !squash && (state == RUN);
  assign level    = count - {1'b0, pop};

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_r;
  assign bad_target    = redirect && (jmp_addr[1:0] != 2'b00);
  assign target        = jmp_addr;
  assign trap_misalign = trap_r;
`else
  assign bad_target    = 1'b0;
  assign target        = jmp_addr & 32'hFFFF_FFFC;
  assign trap_misalign = 1'b0;
`endif

  // Next FIFO contents: head in slot 0; a redirect discards everything including a same-cycle push
  always_comb begin
    count_n = count;
    data0_n = data0;
    pc0_n   = pc0;
    data1_n = data1;
    pc1_n   = pc1;
    if (redirect) begin
      count_n = 2'd0;
    end else begin
      if (pop) begin
        data0_n = data1;
        pc0_n   = pc1;
      end else begin
        data0_n = data0;
        pc0_n   = pc0;
      end
      if (push && (level == 2'd0)) begin
        data0_n = imem_rsp_data;
        pc0_n   = pend_pc;
      end else if (push) begin
        data1_n = imem_rsp_data;
        pc1_n   = pend_pc;
      end else begin
        data1_n = data1;
        pc1_n   = pc1;
      end
      count_n = count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Fetch FSM, PC, in-flight tracking and FIFO registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      active      <= 1'b0;
      fetch_pc    <= RESET_PC;
      pend_pc     <= RESET_PC;
      outstanding <= 1'b0;
      squash      <= 1'b0;
      count       <= 2'd0;
      data0       <= 32'h0000_0000;
      pc0         <= 32'h0000_0000;
      data1       <= 32'h0000_0000;
      pc1         <= 32'h0000_0000;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_r      <= 1'b0;
`endif
    end else begin
      active <= 1'b1;
      count  <= count_n;
      data0  <= data0_n;
      pc0    <= pc0_n;
      data1  <= data1_n;
      pc1    <= pc1_n;
      if (accept) begin
        outstanding <= 1'b1;
        pend_pc     <= fetch_pc;
      end else if (rsp) begin
        outstanding <= 1'b0;
      end
      case (state)
        RUN: begin
          // A request still in flight after a redirect must be squashed before refetching
          if (redirect && !bad_target) begin
            fetch_pc <= target;
            if (accept || (outstanding && !rsp)) begin
              squash <= 1'b1;
              state  <= FLUSH;
            end
          end
`ifdef FETCH_MISALIGN_TRAP_EN
          else if (bad_target) begin
            state  <= TRAP;
            trap_r <= 1'b1;
          end
`endif
          else if (accept) begin
            fetch_pc <= fetch_pc + 32'd4;
          end
        end
        FLUSH: begin
          if (rsp) begin
            squash <= 1'b0;
            state  <= RUN;
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        TRAP: state <= TRAP;
`endif
        default: state <= RUN;
      endcase
    end
  end

endmodule
